// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch-side PC sequencer with Start/Done handshake and run-cycle counter
// Optional taken-branch counter output TakenCnt is enabled by defining PC_PERF_CNT_EN.
module program_counter #(
  parameter int PCW  = 10,
  parameter int OFFW = 8,
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            BranchEn,
  input  logic            Jump,
  input  logic [OFFW-1:0] Offset,
  input  logic            Halt,
  output logic [PCW-1:0]  PC,
  output logic            Busy,
  output logic            Done,
  output logic [CNTW-1:0] CycleCnt
`ifdef PC_PERF_CNT_EN
  ,
  output logic [CNTW-1:0] TakenCnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PCW-1:0]  PC_ONE  = PCW'(1);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [CNTW-1:0] cyc_q, cyc_d;

  logic            launch;
  logic            advance;
  logic            take_branch;
  logic [PCW-1:0]  offset_ext;

  assign launch      = (state_q != ST_RUN) && Start;
  assign advance     = (state_q == ST_RUN) && !Stall;
  // BranchEn gates Jump first so an unknown Jump cannot reach the PC mux.
  assign take_branch = advance && !Halt && (BranchEn & Jump);
  assign offset_ext  = {{(PCW-OFFW){Offset[OFFW-1]}}, Offset};

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_RUN;
      ST_RUN:  if (!Stall && Halt) state_d = ST_DONE;
      ST_DONE: if (Start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    cyc_d = cyc_q;
    if (launch) begin
      pc_d  = '0;
      cyc_d = '0;
    end else if (state_q == ST_RUN) begin
      // Counts every RUN cycle, stalled or not, and sticks at all-ones.
      cyc_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_ONE;
      if (take_branch)
        pc_d = pc_q + offset_ext;
      else if (advance && !Halt)
        pc_d = pc_q + PC_ONE;
    end
  end

  always_comb begin
    Busy     = (state_q == ST_RUN);
    Done     = (state_q == ST_DONE);
    PC       = pc_q;
    CycleCnt = cyc_q;
  end

`ifdef PC_PERF_CNT_EN
  logic [CNTW-1:0] taken_q, taken_d;

  always_ff @(posedge Clk) begin
    if (!Reset)
      taken_q <= '0;
    else
      taken_q <= taken_d;
  end

  always_comb begin
    taken_d = taken_q;
    if (launch)
      taken_d = '0;
    else if (take_branch && taken_q != CNT_MAX)
      taken_d = taken_q + CNT_ONE;
  end

  assign TakenCnt = taken_q;
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - randomized and directed self-checking bench for program_counter
module tb_program_counter;

  localparam int PCW  = 10;
  localparam int OFFW = 8;
  localparam int CNTW = 16;

  logic            Clk = 1'b0;
  logic            Reset, Start, Stall, BranchEn, Jump, Halt;
  logic [OFFW-1:0] Offset;
  logic [PCW-1:0]  PC, PC_s;
  logic            Busy, Done, Busy_s, Done_s;
  logic [CNTW-1:0] CycleCnt;
  logic [3:0]      CycleCnt_s;
`ifdef PC_PERF_CNT_EN
  logic [CNTW-1:0] TakenCnt;
  logic [3:0]      TakenCnt_s;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model: plain integers and run/done flags.
  int m_pc, m_cyc, m_taken;
  bit m_run, m_done;

  always #5 Clk = ~Clk;

  program_counter #(.PCW(PCW), .OFFW(OFFW), .CNTW(CNTW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
    .Jump(Jump), .Offset(Offset), .Halt(Halt), .PC(PC), .Busy(Busy), .Done(Done),
    .CycleCnt(CycleCnt)
`ifdef PC_PERF_CNT_EN
    , .TakenCnt(TakenCnt)
`endif
  );

  program_counter #(.PCW(PCW), .OFFW(OFFW), .CNTW(4)) dut_small (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
    .Jump(Jump), .Offset(Offset), .Halt(Halt), .PC(PC_s), .Busy(Busy_s), .Done(Done_s),
    .CycleCnt(CycleCnt_s)
`ifdef PC_PERF_CNT_EN
    , .TakenCnt(TakenCnt_s)
`endif
  );

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic void model_update();
    bit taken;
    taken = BranchEn && (Jump === 1'b1);
    if (!Reset) begin
      m_run = 0; m_done = 0; m_pc = 0; m_cyc = 0; m_taken = 0;
    end else if (!m_run) begin
      if (Start) begin
        m_run = 1; m_done = 0; m_pc = 0; m_cyc = 0; m_taken = 0;
      end
    end else begin
      m_cyc = sat(m_cyc + 1, 65535);
      if (!Stall) begin
        if (Halt) begin
          m_run = 0; m_done = 1;
        end else if (taken) begin
          m_pc    = (m_pc + int'($signed(Offset))) & ((1 << PCW) - 1);
          m_taken = sat(m_taken + 1, 65535);
        end else begin
          m_pc = (m_pc + 1) & ((1 << PCW) - 1);
        end
      end
    end
  endfunction

  task automatic step();
    model_update();
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet();
    Start = 0; Stall = 0; BranchEn = 0; Jump = 0; Offset = '0; Halt = 0;
  endtask

  task automatic launch();
    quiet();
    Reset = 0; step();
    Reset = 1; Start = 1; step();
    Start = 0;
  endtask

  task automatic take(input logic [OFFW-1:0] off);
    BranchEn = 1; Jump = 1; Offset = off; step();
    quiet();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      Reset = 0; Start = 1'($urandom); Stall = 1'($urandom); BranchEn = 1'($urandom);
      Jump = 1'($urandom); Offset = 8'($urandom); Halt = 1'($urandom);
      step();
    end
    total++; if ({PC, Busy, Done, CycleCnt} !== '0) $display("FAIL reset_state: PC=%0h Busy=%0b Done=%0b Cnt=%0h expected all 0", PC, Busy, Done, CycleCnt); else passed++;
    quiet(); Reset = 1; Start = 1; step(); Start = 0;
    total++; if (Busy !== 1'b1 || PC !== 10'd0) $display("FAIL launch: Busy=%0b PC=%0h expected 1/0", Busy, PC); else passed++;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (PC !== 10'(i) || CycleCnt !== 16'(i)) $display("FAIL seq_pc: PC=%0h Cnt=%0h expected %0h", PC, CycleCnt, i); else passed++;
    end
  endtask

  task automatic test_branch();
    launch();
    take(8'd5);
    take(8'hFD);
    total++; if (PC !== 10'd2) $display("FAIL branch_neg: PC=%0h expected 2", PC); else passed++;
    take(8'd3);
    BranchEn = 1; Jump = 0; Offset = 8'hFD; step(); quiet();
    total++; if (PC !== 10'd6) $display("FAIL branch_not_taken: PC=%0h expected 6", PC); else passed++;
    take(8'hFF);
    BranchEn = 0; Jump = 1'bx; Offset = 8'hFD; step(); quiet();
    total++; if (PC !== 10'd6) $display("FAIL jump_x: PC=%0h expected 6", PC); else passed++;
    take(8'd0);
    total++; if (PC !== 10'd6) $display("FAIL self_loop: PC=%0h expected 6", PC); else passed++;
  endtask

  task automatic test_wrap();
    launch();
    take(8'hFF);
    total++; if (PC !== 10'h3FF) $display("FAIL wrap_neg_from0: PC=%0h expected 3ff", PC); else passed++;
    step();
    total++; if (PC !== 10'h000) $display("FAIL wrap_inc: PC=%0h expected 0", PC); else passed++;
    step();
    take(8'hFC);
    total++; if (PC !== 10'h3FD) $display("FAIL wrap_neg_from1: PC=%0h expected 3fd", PC); else passed++;
  endtask

  task automatic test_stall_halt();
    launch();
    take(8'd7);
    for (int i = 0; i < 3; i++) begin
      Stall = 1; Halt = 1; BranchEn = 1; Jump = 1; Offset = 8'd9; step();
      total++; if (PC !== 10'd7 || Busy !== 1'b1 || Done !== 1'b0) $display("FAIL stall_hold: PC=%0h Busy=%0b Done=%0b expected 7/1/0", PC, Busy, Done); else passed++;
    end
    total++; if (CycleCnt !== 16'd4) $display("FAIL stall_count: Cnt=%0h expected 4", CycleCnt); else passed++;
    Stall = 0; step(); quiet();
    total++; if (Done !== 1'b1 || Busy !== 1'b0 || PC !== 10'd7 || CycleCnt !== 16'd5) $display("FAIL halt_wins: Done=%0b Busy=%0b PC=%0h Cnt=%0h expected 1/0/7/5", Done, Busy, PC, CycleCnt); else passed++;
    BranchEn = 1; Jump = 1; Offset = 8'd3; step(); step(); quiet();
    total++; if (Done !== 1'b1 || PC !== 10'd7 || CycleCnt !== 16'd5) $display("FAIL done_frozen: Done=%0b PC=%0h Cnt=%0h expected 1/7/5", Done, PC, CycleCnt); else passed++;
  endtask

  task automatic test_restart();
    Start = 1; step(); Start = 0;
    total++; if (Busy !== 1'b1 || Done !== 1'b0 || PC !== 10'd0 || CycleCnt !== 16'd0) $display("FAIL restart: Busy=%0b Done=%0b PC=%0h Cnt=%0h expected 1/0/0/0", Busy, Done, PC, CycleCnt); else passed++;
    take(8'd20);
    total++; if (PC !== 10'd20) $display("FAIL reach_20: PC=%0h expected 14", PC); else passed++;
    Reset = 0; Halt = 1; step(); Reset = 1; quiet();
    total++; if (Busy !== 1'b0 || Done !== 1'b0 || PC !== 10'd0) $display("FAIL reset_mid_run: Busy=%0b Done=%0b PC=%0h expected 0/0/0", Busy, Done, PC); else passed++;
    step();
    total++; if (Done !== 1'b0 || Busy !== 1'b0) $display("FAIL no_done_pulse: Done=%0b Busy=%0b expected 0/0", Done, Busy); else passed++;
  endtask

  task automatic test_saturate();
    launch();
    repeat (20) step();
    total++; if (CycleCnt_s !== 4'hF) $display("FAIL cnt_saturate: Cnt=%0h expected f", CycleCnt_s); else passed++;
    total++; if (CycleCnt !== 16'd20) $display("FAIL cnt_wide: Cnt=%0h expected 14", CycleCnt); else passed++;
  endtask

`ifdef PC_PERF_CNT_EN
  task automatic test_taken_cnt();
    launch();
    repeat (4) take(8'd2);
    Stall = 1; BranchEn = 1; Jump = 1; Offset = 8'd2; step(); quiet();
    repeat (2) begin BranchEn = 1; Jump = 0; step(); quiet(); end
    Halt = 1; BranchEn = 1; Jump = 1; step(); quiet();
    total++; if (TakenCnt !== 16'd4 || Done !== 1'b1) $display("FAIL taken_cnt: Taken=%0h Done=%0b expected 4/1", TakenCnt, Done); else passed++;
  endtask
`endif

  task automatic test_random();
    launch();
    for (int i = 0; i < 400; i++) begin
      Reset    = ($urandom_range(63) != 0);
      Start    = ($urandom_range(3) == 0);
      Stall    = ($urandom_range(3) == 0);
      BranchEn = 1'($urandom);
      Jump     = 1'($urandom);
      Offset   = 8'($urandom);
      Halt     = ($urandom_range(15) == 0);
      step();
      total++;
      if (PC !== 10'(m_pc) || Busy !== m_run || Done !== m_done || CycleCnt !== 16'(m_cyc) || CycleCnt_s !== 4'(sat(m_cyc, 15)))
        $display("FAIL random[%0d]: PC=%0h Busy=%0b Done=%0b Cnt=%0h CntS=%0h expected %0h/%0b/%0b/%0h/%0h",
                 i, PC, Busy, Done, CycleCnt, CycleCnt_s, m_pc, m_run, m_done, m_cyc, sat(m_cyc, 15));
      else passed++;
`ifdef PC_PERF_CNT_EN
      total++; if (TakenCnt !== 16'(m_taken)) $display("FAIL random_taken[%0d]: Taken=%0h expected %0h", i, TakenCnt, m_taken); else passed++;
`endif
    end
    quiet(); Reset = 1;
  endtask

  initial begin
    Reset = 0;
    quiet();
    m_run = 0; m_done = 0; m_pc = 0; m_cyc = 0; m_taken = 0;
    #1;
    test_reset();
    test_branch();
    test_wrap();
    test_stall_halt();
    test_restart();
    test_saturate();
`ifdef PC_PERF_CNT_EN
    test_taken_cnt();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
